alu_sequencer: RTL and testbench

Sequences requests onto the shared one's-complement ALU (AD, SU, MASK, MP0/MP1, DV0/DV1), expanding MP and DV into their two ALU steps. Accepts one request at a time over a valid/ready handshake, latches the operands, drives the ALU command and operands for a fixed number of cycles per step, and captures the results. Returns a response over a second valid/ready handshake. Sits between instruction control and the ALU, and is the only driver of the ALU's `A`, `B` and `command` inputs.

---
 rtl/alu_sequencer.sv | 113 +++++++++++
 tb/tb_alu_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Sequences AD/SU/MASK/MP/DV requests onto the shared one's-complement ALU.
// Optional operand parity checking is enabled by defining PARITY_CHECK_EN.
module alu_sequencer #(
  parameter int unsigned STEP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_command,
  input  logic [14:0] alu_res,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [14:0] rsp_hi,
  output logic [14:0] rsp_lo,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, STEP1, STEP2, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(STEP_CYCLES - 1);

  state_t     state, state_nx;
  logic [3:0] cnt;
  logic [2:0] op_q;
  logic       accept, op_illegal, parity_err, req_err, two_step, cnt_done;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign accept     = req_valid & req_ready;
  assign op_illegal = (req_op > 3'd4);
`ifdef PARITY_CHECK_EN
  assign parity_err = ~(^req_a) | ~(^req_b);
`else
  assign parity_err = 1'b0;
`endif
  assign req_err  = op_illegal | parity_err;
  assign two_step = (op_q == 3'd3) || (op_q == 3'd4);
  assign cnt_done = (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Rejected requests still pass through STEP1 for a single cycle so the
  // error response appears one edge after accept, with no ALU step run.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = STEP1;
      STEP1:   if (cnt_done) state_nx = (rsp_err || !two_step) ? DONE : STEP2;
      STEP2:   if (cnt_done) state_nx = DONE;
      DONE:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      op_q        <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_command <= '0;
      rsp_hi      <= '0;
      rsp_lo      <= '0;
      rsp_err     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            alu_a   <= req_a;
            alu_b   <= req_b;
            op_q    <= req_op;
            rsp_hi  <= '0;
            rsp_lo  <= '0;
            rsp_err <= req_err;
            cnt     <= req_err ? '0 : CNT_LOAD;
            if (!req_err) alu_command <= (req_op == 3'd4) ? 3'd5 : req_op;
          end
        end
        STEP1: begin
          if (!cnt_done) begin
            cnt <= cnt - 4'd1;
          end else if (!rsp_err) begin
            if (two_step) begin
              rsp_hi      <= alu_res;
              cnt         <= CNT_LOAD;
              alu_command <= (op_q == 3'd3) ? 3'd4 : 3'd6;
            end else begin
              rsp_lo <= alu_res;
            end
          end
        end
        STEP2: begin
          if (!cnt_done) cnt <= cnt - 4'd1;
          else           rsp_lo <= alu_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed vectors, reset/hold corner cases and
// randomized requests checked against a transaction-level model.
module tb_alu_sequencer;

  localparam int unsigned STEP = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_a, req_b;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_command;
  logic [14:0] alu_res;
  logic        rsp_valid, rsp_ready;
  logic [14:0] rsp_hi, rsp_lo;
  logic        rsp_err, busy;

  logic [14:0] lut [8];
  logic        mix;
  logic [2:0]  last_cmd;
  int          errors = 0;
  int          checks = 0;

  alu_sequencer #(.STEP_CYCLES(STEP)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_command(alu_command), .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] mixv(input logic [15:0] a, input logic [15:0] b);
    return a[15:1] ^ {b[14:1], b[15]};
  endfunction

  // Stub ALU: per-command value, optionally mixed with the operands.
  assign alu_res = lut[alu_command] ^ (mix ? mixv(alu_a, alu_b) : 15'h0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_req(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int hold, input logic e_err,
                         input logic [14:0] e_hi, input logic [14:0] e_lo);
    int lat, k;
    logic [2:0] c1, c2, ec;
    logic cmd_ok, stable_ok;
    c1  = (op == 3'd4) ? 3'd5 : op;
    c2  = (op == 3'd3) ? 3'd4 : 3'd6;
    lat = e_err ? 1 : ((op == 3'd3 || op == 3'd4) ? 2 * STEP : STEP);
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    rsp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 3'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
    check("alu_a_latch", alu_a, a);
    check("alu_b_latch", alu_b, b);
    k = 0; cmd_ok = 1'b1;
    while (!rsp_valid && k < 200) begin
      ec = e_err ? last_cmd : ((k < STEP) ? c1 : c2);
      if (alu_command !== ec || !busy || req_ready) cmd_ok = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    check("cmd_seq", cmd_ok, 1);
    check("latency", k, lat);
    if (!e_err) last_cmd = (lat > STEP) ? c2 : c1;
    check("rsp_err", rsp_err, e_err);
    check("rsp_hi", rsp_hi, e_hi);
    check("rsp_lo", rsp_lo, e_lo);
    stable_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      @(posedge clk); #1;
      if (!rsp_valid || rsp_hi !== e_hi || rsp_lo !== e_lo || rsp_err !== e_err ||
          req_ready || alu_a !== a || alu_b !== b) stable_ok = 1'b0;
    end
    if (hold > 0) check("done_hold", stable_ok, 1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("rsp_valid_drop", rsp_valid, 0);
    check("req_ready_after", req_ready, 1);
    check("alu_a_held", alu_a, a);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a, b;
    int          hold;
    logic        err;
    logic [14:0] hi, lo;
  } vec_t;

  vec_t tv [7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rv_seen, perr, e_err;
    logic [2:0]  op, c1, c2;
    logic [15:0] a, b;
    logic [14:0] e_hi, e_lo;

    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0; mix = 1'b0; last_cmd = '0;
    lut[0] = 15'h7FFF; lut[1] = 15'h0AAA; lut[2] = 15'h1555; lut[3] = 15'h0012;
    lut[4] = 15'h0345; lut[5] = 15'h2222; lut[6] = 15'h3333; lut[7] = 15'h4444;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_cmd", alu_command, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_hi", rsp_hi, 0);
    check("rst_rsp_lo", rsp_lo, 0);
    check("rst_busy", busy, 0);
    @(negedge clk) reset = 1'b0;

    tv[0] = '{3'd0, 16'b0000000100110011, 16'b1111111011001100, 1, 1'b0, 15'h0000, 15'h7FFF};
    tv[1] = '{3'd3, 16'h0001, 16'h0002, 0, 1'b0, 15'h0012, 15'h0345};
    tv[2] = '{3'd7, 16'h1234, 16'h5678, 1, 1'b1, 15'h0000, 15'h0000};
`ifdef PARITY_CHECK_EN
    tv[3] = '{3'd0, 16'h0000, 16'h0001, 1, 1'b1, 15'h0000, 15'h0000};
`else
    tv[3] = '{3'd0, 16'h0000, 16'h0001, 1, 1'b0, 15'h0000, 15'h7FFF};
`endif
    tv[4] = '{3'd4, 16'h0007, 16'h0008, 5, 1'b0, 15'h2222, 15'h3333};
    tv[5] = '{3'd1, 16'h0001, 16'h0001, 2, 1'b0, 15'h0000, 15'h0AAA};
    tv[6] = '{3'd2, 16'h0001, 16'h0001, 0, 1'b0, 15'h0000, 15'h1555};
    for (int i = 0; i < 7; i++)
      run_req(tv[i].op, tv[i].a, tv[i].b, tv[i].hold, tv[i].err, tv[i].hi, tv[i].lo);

    // Reset pulsed while a DV is in its second step.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd4; req_a = 16'h0007; req_b = 16'h0008;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (STEP) @(posedge clk);
    #1;
    check("dv_in_step2", alu_command, 6);
    reset = 1'b1;
    #1;
    check("midrst_req_ready", req_ready, 1);
    check("midrst_alu_a", alu_a, 0);
    check("midrst_alu_b", alu_b, 0);
    check("midrst_cmd", alu_command, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_rsp_hi", rsp_hi, 0);
    check("midrst_rsp_lo", rsp_lo, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk) reset = 1'b0;
    last_cmd = '0;
    rsp_ready = 1'b1; rv_seen = 1'b0;
    repeat (2 * STEP + 2) begin
      @(posedge clk); #1;
      rv_seen |= rsp_valid;
    end
    check("no_rsp_after_rst", rv_seen, 0);
    rsp_ready = 1'b0;
    run_req(3'd3, 16'h0001, 16'h0002, 1, 1'b0, 15'h0012, 15'h0345);

    // Randomized requests against the transaction model.
    mix = 1'b1;
    for (int i = 0; i < 8; i++) lut[i] = 15'($urandom);
    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      a = 16'($urandom); a[0] = ~(^a[15:1]);
      b = 16'($urandom); b[0] = ~(^b[15:1]);
      if ($urandom_range(0, 5) == 0) a[0] = ~a[0];
      if ($urandom_range(0, 5) == 0) b[0] = ~b[0];
`ifdef PARITY_CHECK_EN
      perr = ~(^a) | ~(^b);
`else
      perr = 1'b0;
`endif
      e_err = (op > 3'd4) | perr;
      c1 = (op == 3'd4) ? 3'd5 : op;
      c2 = (op == 3'd3) ? 3'd4 : 3'd6;
      if (e_err) begin
        e_hi = '0; e_lo = '0;
      end else if (op == 3'd3 || op == 3'd4) begin
        e_hi = lut[c1] ^ mixv(a, b);
        e_lo = lut[c2] ^ mixv(a, b);
      end else begin
        e_hi = '0;
        e_lo = lut[c1] ^ mixv(a, b);
      end
      run_req(op, a, b, $urandom_range(0, 3), e_err, e_hi, e_lo);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
